instruction_fetch_controller: RTL
=================================

// Module: instruction_fetch_controller
// PURPOSE
//  Sequences the instruction memory: owns the fetch PC, issues one read per cycle, and absorbs the
//  memory's 1-cycle registered read latency. Fetched words go into a small FIFO that drives the
//  datapath with a valid/ready handshake. Handles taken-branch redirects, stalls and the
//  end-of-program halt. Sits between the PC/branch logic and InstructionMemory.
// PARAMETERS
//  XLEN        32  data/address width
//  RESET_PC    0   byte address of the first fetch after reset
//  IMEM_WORDS  32  instruction memory depth in words; valid byte range is [0, IMEM_WORDS*4)
//  FIFO_DEPTH  2   fetch buffer entries (>=2)
// PORTS
//  clock            in   1     single clock, all state on posedge
//  reset            in   1     synchronous, active-high
//  enable           in   1     1 = issue new fetches; 0 = no new issue, in-flight read still completes
//  imem_addr        out  XLEN  byte address to InstructionMemory (word index = imem_addr>>2)
//  imem_rdata       in   XLEN  word returned by memory, valid the cycle after the issuing edge
//  redirect_valid   in   1     taken branch/jump: flush and refetch from redirect_target
//  redirect_target  in   XLEN  new byte PC
//  inst_valid       out  1     FIFO head valid
//  inst_ready       in   1     datapath accepts head when inst_valid && inst_ready
//  inst_out         out  XLEN  instruction at FIFO head
//  inst_pc          out  XLEN  byte PC of inst_out
//  halted           out  1     state == HALT
//  fault            out  1     sticky: HALT was entered via a bad redirect target
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-fetch/mid-redirect): fetch_pc=RESET_PC, FIFO empty, inflight=0,
//    state=RUN. Outputs: imem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, halted=0, fault=0.
//  - States: RUN, HALT. Only reset leaves HALT.
//  - imem_addr = fetch_pc (combinational from register).
//  - Issue at edge k when state==RUN && enable && !redirect_valid && fetch_pc < IMEM_WORDS*4
//    && (count + inflight - pop) < FIFO_DEPTH, where pop = inst_valid && inst_ready.
//    On issue: inflight<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (XLEN wrap, no carry out).
//    No issue: inflight<=0.
//  - Completion at edge k+1 (inflight==1): imem_rdata is enqueued with tag req_pc.
//    Exception: imem_rdata==0 (end-of-program padding) is not enqueued; state<=HALT.
//  - Full-rate fetch: 1 instruction/cycle in steady state with inst_ready=1. First inst_valid
//    appears 2 cycles after reset deasserts.
//  - Sequential fetch_pc reaching IMEM_WORDS*4: no further issue, state<=HALT once inflight==0
//    (no fault). Already-buffered instructions still drain.
//  - redirect_valid (RUN only):
//    - FIFO is flushed and the in-flight result is squashed at the next edge.
//    - A pop in the same cycle still completes: the head is consumed, then the flush applies.
//    - Target aligned (t[1:0]==0) and in range: fetch_pc<=t; issue from t resumes the next cycle.
//    - Target misaligned or >= IMEM_WORDS*4: state<=HALT, fault<=1.
//  - In HALT: no issue; redirect ignored; in-flight result discarded; FIFO contents still drain via
//    the handshake. halted=1.
//  - FIFO: count 0..FIFO_DEPTH, circular pointers wrap modulo FIFO_DEPTH. Push and pop in the same
//    cycle with count==FIFO_DEPTH is legal; the issue rule above guarantees no overflow.
//    Pop on empty is impossible (inst_valid=0). inst_out/inst_pc hold their value while
//    inst_valid && !inst_ready.
// STRUCTURE
//  - Shared package riscv_pkg: XLEN, typedef fetch_state_t {RUN, HALT}, INST_HALT = 32'h0,
//    ALIGN_MASK = 2'b11.
//  - One sub-module fetch_fifo (params WIDTH=2*XLEN, DEPTH=FIFO_DEPTH; push/pop/count/head,
//    sync reset). Control FSM, PC and issue logic live in the top module.
// TESTING
//  1. Reset, enable=1, inst_ready=1, memory preloaded with the program (words 0..10 nonzero,
//     11+ zero) -> pc 0,4,...,40 delivered back-to-back from cycle 2; halted=1 after word 11 is
//     read; fault=0.
//  2. inst_ready=0 for 5 cycles mid-stream -> exactly FIFO_DEPTH entries held, imem_addr frozen,
//     no instruction lost or duplicated when ready returns.
//  3. redirect_valid with target=0x18 while pc 0x8/0xC are buffered -> both dropped; the next
//     delivered inst_pc=0x18, data=word 6.
//  4. Redirect in the same cycle as a pop of pc 0x4 -> 0x4 counted as consumed once; next
//     inst_pc=target.
//  5. Redirect target=0x1A (misaligned) and, in a separate run, target=0x80 (IMEM_WORDS=32) ->
//     halted=1, fault=1, no further issue.
//  6. Assert reset while inflight=1 and the FIFO is full -> next cycle inst_valid=0,
//     imem_addr=RESET_PC, halted=0, fault=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the RV32 front end.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // All-zero word marks the end-of-program padding in instruction memory.
  localparam logic [31:0] INST_HALT  = 32'h0;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer between instruction memory and the datapath.
// Flush empties it in one edge; the head is visible combinationally.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset only because it is a couple of flops and the
      // head must read zero out of reset; a deep RAM would not be reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  no_overflow: assert property (@(posedge clock) disable iff (reset || flush)
    !(push && !pop && count == CNT_W'(DEPTH)));

  no_underflow: assert property (@(posedge clock) disable iff (reset)
    !(pop && count == '0));

endmodule

// File: rtl/instruction_fetch_controller.sv
// Owns the fetch PC, issues one instruction-memory read per cycle, absorbs the
// one-cycle read latency and hands words to the datapath through fetch_fifo.
module instruction_fetch_controller
  import riscv_pkg::*;
#(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_WORDS = 32,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic            halted,
  output logic            fault
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // One extra bit so a memory that fills the whole address space still compares correctly.
  localparam logic [XLEN:0] PC_LIMIT = (XLEN + 1)'(IMEM_WORDS * 4);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            fault_q, fault_d;

  logic             push, flush, pop, issue;
  logic             in_range, target_ok;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic [2*XLEN-1:0] fifo_head;

  assign pop        = inst_valid && inst_ready;
  assign inst_valid = (count != '0);

  // Slots that will be taken after this edge if nothing new is issued.
  assign occupancy = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign in_range  = {1'b0, fetch_pc_q} < PC_LIMIT;
  assign target_ok = is_aligned(redirect_target[1:0]) && ({1'b0, redirect_target} < PC_LIMIT);

  assign issue = (state_q == RUN) && enable && !redirect_valid && in_range
              && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    fault_d    = fault_q;
    push       = 1'b0;
    flush      = 1'b0;

    if (issue) begin
      inflight_d = 1'b1;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          // Buffered words and the read in flight belong to the wrong path.
          flush = 1'b1;
          if (target_ok) begin
            fetch_pc_d = redirect_target;
          end else begin
            state_d = HALT;
            fault_d = 1'b1;
          end
        end else begin
          if (inflight_q) begin
            if (imem_rdata == XLEN'(INST_HALT)) state_d = HALT;
            else                                push    = 1'b1;
          end
          if (!in_range && !inflight_q) state_d = HALT;
        end
      end
      HALT: begin
        // Only reset leaves HALT; the buffer keeps draining on its own.
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      fault_q    <= fault_d;
    end
  end

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({req_pc_q, imem_rdata}),
    .head  (fifo_head),
    .count (count)
  );

  assign imem_addr = fetch_pc_q;
  assign inst_pc   = fifo_head[2*XLEN-1:XLEN];
  assign inst_out  = fifo_head[XLEN-1:0];
  assign halted    = (state_q == HALT);
  assign fault     = fault_q;

endmodule
